i2s_rx: RTL and testbench
=========================

I2S_RX -- requirements
Module: i2s_rx

Interface
- REQ-001 Parameter SLOT_BITS, default 32: sclk periods per channel slot; legal range 16..32.
- REQ-002 Parameter SAMPLE_BITS, default 16: captured word width, Q2.14 two's complement.
- REQ-003 clk  input  1: system clock, 100 MHz nominal, single clock domain.
- REQ-004 reset  input  1: asynchronous, active-low reset.
- REQ-005 sclk  input  1: I2S bit clock, asynchronous to clk.
- REQ-006 l_r_clk  input  1: I2S word select; 0 = left slot, 1 = right slot.
- REQ-007 sd  input  1: I2S serial data, MSB first, changes on sclk falling edge.
- REQ-008 sample_l  output  16: last complete left word.
- REQ-009 sample_r  output  16: last complete right word.
- REQ-010 sample_valid  output  1: one-clk pulse; new stereo pair available.
- REQ-011 frame_err  output  1: one-clk pulse; a slot ended before SAMPLE_BITS bits were captured.

Function
- REQ-012 sclk, l_r_clk and sd SHALL each pass through a 2-flop synchronizer before use.
- REQ-013 An sclk rising edge is detected as synchronized sclk 1 now and 0 in the previous clk cycle; all capture logic advances only on detected rising edges.
- REQ-014 At each detected edge, the block samples synchronized sd and l_r_clk together.
- REQ-015 A slot starts when the sampled l_r_clk differs from its value at the previous edge; the MSB is the sd bit at the next edge (standard I2S one-bit delay).
- REQ-016 States: IDLE (waits for first l_r_clk change after reset), DELAY (one edge, skips the I2S delay bit), SHIFT (captures SAMPLE_BITS bits MSB first), HOLD (ignores remaining slot bits).
- REQ-017 Transitions: IDLE->DELAY on slot start; DELAY->SHIFT on next edge; SHIFT->HOLD when the bit counter reaches SAMPLE_BITS; HOLD->DELAY on slot start.
- REQ-018 A slot start in SHIFT SHALL pulse frame_err, discard the partial word, leave sample_l/sample_r unchanged, and go to DELAY.
- REQ-019 On completing a left word, it is held internally; sample_l is not yet updated.
- REQ-020 On completing a right word, sample_l and sample_r SHALL update in the same cycle, and sample_valid SHALL pulse one clk later.
- REQ-021 The right word completes when the SHIFT->HOLD transition occurs in the right slot.
- REQ-022 Latency: the sampled LSB appears on the outputs at most 5 clk after the physical sclk rising edge.
- REQ-023 Bits beyond SAMPLE_BITS in a slot SHALL be ignored, with no truncation rounding.
- REQ-024 The bit counter is 5 bits and SHALL never wrap inside a slot.
- REQ-025 Correct operation requires f_clk >= 8 x f_sclk.

Reset
- REQ-026 While reset is 0: sample_l=0, sample_r=0, sample_valid=0, frame_err=0, state=IDLE, synchronizers cleared.
- REQ-027 When reset deasserts mid-frame, the next sample_valid SHALL occur only after a full left slot plus a full right slot have been captured.

Configuration
- REQ-028 Macro I2S_RX_STEREO_EN. When defined, behaviour is as REQ-019..021.
- REQ-029 When I2S_RX_STEREO_EN is not defined, right slots SHALL be ignored (no SHIFT).
- REQ-030 Without I2S_RX_STEREO_EN, sample_r SHALL be tied equal to sample_l.
- REQ-031 Without I2S_RX_STEREO_EN, sample_valid SHALL pulse after each completed left word.

Structure
- REQ-032 Shared package audio_pkg SHALL hold: typedef sample_t (logic signed [15:0]), the rx state enum, and the default SLOT_BITS/SAMPLE_BITS constants.
- REQ-033 One sub-module, sync2, SHALL implement the 2-flop synchronizer and be instantiated three times.

Verification
- REQ-034 Left word 0x4000 (+1.0) and right word 0xC000 (-1.0) in 32-bit slots: sample_l=0x4000, sample_r=0xC000, exactly one sample_valid per frame.
- REQ-035 48 kHz frames carrying 0x7FFF/0x8000 across 100 frames: 100 sample_valid pulses, values exact, frame_err never asserted.
- REQ-036 Right slot cut to 10 sclk periods: frame_err pulses once, outputs hold their previous pair, next full frame recovers.
- REQ-037 Reset asserted mid-right-slot: outputs read 0 immediately (asynchronous); the first valid occurs after the next complete L+R frame.
- REQ-038 With I2S_RX_STEREO_EN undefined, left=0x1234 and right=0x5678: sample_l=sample_r=0x1234, one pulse per left slot.
- REQ-039 SLOT_BITS=16 with back-to-back slots: every word is captured with the one-bit delay honoured, and no frame_err occurs.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types: Q2.14 sample word, I2S receiver state encoding and default sizes.
package audio_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } rx_state_e;

  localparam int SLOT_BITS_DEF   = 32;
  localparam int SAMPLE_BITS_DEF = 16;
  localparam int CNT_W           = 5;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous input bit, cleared by the async reset.
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sclk/l_r_clk/sd on clk and captures SAMPLE_BITS MSB-first per slot.
// Define I2S_RX_STEREO_EN for left+right capture; without it only left words are captured.
module i2s_rx
  import audio_pkg::*;
#(
  parameter int SLOT_BITS   = SLOT_BITS_DEF,
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sclk,
  input  logic                   l_r_clk,
  input  logic                   sd,
  output logic [SAMPLE_BITS-1:0] sample_l,
  output logic [SAMPLE_BITS-1:0] sample_r,
  output logic                   sample_valid,
  output logic                   frame_err
);

`ifdef I2S_RX_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLE_BITS - 1);

  if (SLOT_BITS < 16 || SLOT_BITS > 32 || SAMPLE_BITS != $bits(sample_t)) begin : g_cfg_err
    $error("i2s_rx: unsupported SLOT_BITS/SAMPLE_BITS combination");
  end

  logic sclk_s, lr_s, sd_s;

  sync2 u_sync_sclk (.clk_i(clk), .rst_ni(reset), .d_i(sclk),    .q_o(sclk_s));
  sync2 u_sync_lr   (.clk_i(clk), .rst_ni(reset), .d_i(l_r_clk), .q_o(lr_s));
  sync2 u_sync_sd   (.clk_i(clk), .rst_ni(reset), .d_i(sd),      .q_o(sd_s));

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_prev_q, lr_prev_q, primed_q, chan_q, left_ok_q;
  logic             upd_p_q, valid_q, err_q;
  sample_t          shift_q, left_q, sample_l_q, sample_r_q, word_w;
  logic             edge_w, start_w, last_w, take_w, cap_w, done_w, err_w, upd_w;

  // The first edge after reset only learns l_r_clk, so a partial slot is never taken as a start.
  assign edge_w  = sclk_s & ~sclk_prev_q;
  assign start_w = edge_w & primed_q & (lr_s ^ lr_prev_q);
  assign last_w  = (cnt_q == LAST_CNT);
  assign take_w  = STEREO | ~chan_q;
  assign word_w  = {shift_q[SAMPLE_BITS-2:0], sd_s};
  assign upd_w   = done_w & (STEREO ? (chan_q & left_ok_q) : ~chan_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (edge_w) begin
      unique case (state_q)
        ST_IDLE:  if (start_w) state_d = ST_DELAY;
        ST_DELAY: begin
          if (start_w)     state_d = ST_DELAY;
          else if (take_w) state_d = ST_SHIFT;
          else             state_d = ST_HOLD;
        end
        ST_SHIFT: begin
          if (start_w)     state_d = ST_DELAY;
          else if (last_w) state_d = ST_HOLD;
        end
        ST_HOLD:  if (start_w) state_d = ST_DELAY;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // The LSB of a slot-filling word arrives on the edge that starts the next slot.
  always_comb begin
    cap_w  = 1'b0;
    done_w = 1'b0;
    err_w  = 1'b0;
    if (edge_w) begin
      unique case (state_q)
        ST_DELAY: cap_w = ~start_w & take_w;
        ST_SHIFT: begin
          cap_w  = ~start_w | last_w;
          done_w = last_w;
          err_w  = start_w & ~last_w;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (start_w)    cnt_d = '0;
    else if (cap_w) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_prev_q <= 1'b0;
      lr_prev_q   <= 1'b0;
      primed_q    <= 1'b0;
      chan_q      <= 1'b0;
      cnt_q       <= '0;
      left_ok_q   <= 1'b0;
      upd_p_q     <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      if (edge_w) begin
        primed_q  <= 1'b1;
        lr_prev_q <= lr_s;
      end
      if (start_w) chan_q <= lr_s;
      cnt_q <= cnt_d;
      if (err_w)       left_ok_q <= 1'b0;
      else if (done_w) left_ok_q <= ~chan_q;
      upd_p_q <= upd_w;
      valid_q <= upd_p_q;
      err_q   <= err_w;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_w)              shift_q <= word_w;
    if (done_w && !chan_q)  left_q  <= word_w;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_l_q <= '0;
      sample_r_q <= '0;
    end else if (upd_w) begin
      sample_l_q <= STEREO ? left_q : word_w;
      sample_r_q <= word_w;
    end
  end

  assign sample_l     = sample_l_q;
  assign sample_r     = STEREO ? sample_r_q : sample_l_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: 32-bit slot instance plus a SLOT_BITS=16 instance on the same bus.
`timescale 1ns/1ps
module tb_i2s_rx;

`ifdef I2S_RX_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif
  localparam int HALF = 40;

  logic        clk = 1'b0, reset = 1'b1, sclk = 1'b0, l_r_clk = 1'b0, sd = 1'b0;
  logic [15:0] sample_l, sample_r, s16_l, s16_r;
  logic        sample_valid, frame_err, v16, e16;

  int   checks = 0, errors = 0;
  int   vcnt = 0, ecnt = 0, v16cnt = 0, e16cnt = 0;
  logic [15:0] prv_l = '0, prv_r = '0;
  time  t_upd = 0, t_val = 0;
  time  t_lsb [2];
  logic prev_bit = 1'b0;

  always #5 clk = ~clk;

  i2s_rx dut (
    .clk(clk), .reset(reset), .sclk(sclk), .l_r_clk(l_r_clk), .sd(sd),
    .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid), .frame_err(frame_err)
  );

  i2s_rx #(.SLOT_BITS(16)) dut16 (
    .clk(clk), .reset(reset), .sclk(sclk), .l_r_clk(l_r_clk), .sd(sd),
    .sample_l(s16_l), .sample_r(s16_r), .sample_valid(v16), .frame_err(e16)
  );

  always @(negedge clk) begin
    if (sample_valid) begin
      vcnt  <= vcnt + 1;
      t_val <= $time;
    end
    if (frame_err) ecnt   <= ecnt + 1;
    if (v16)       v16cnt <= v16cnt + 1;
    if (e16)       e16cnt <= e16cnt + 1;
    if (sample_l !== prv_l || sample_r !== prv_r) t_upd <= $time;
    prv_l <= sample_l;
    prv_r <= sample_r;
  end

  task automatic period(input logic lr, input logic b);
    sclk = 1'b0; l_r_clk = lr; sd = b;
    #(HALF);
    sclk = 1'b1;
    #(HALF);
  endtask

  // sd lags the slot by one period: the bit sent now belongs to the previous period's word bit.
  task automatic send_slot(input logic lr, input logic [15:0] w, input int len);
    logic nb;
    for (int i = 0; i < len; i++) begin
      nb = (i < 16) ? w[15 - i] : 1'b0;
      if (i == 16) t_lsb[lr] = $time + HALF;
      period(lr, prev_bit);
      prev_bit = nb;
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int len_l, input int len_r);
    send_slot(1'b0, l, len_l);
    send_slot(1'b1, r, len_r);
  endtask

  task automatic do_reset();
    reset = 1'b0; sclk = 1'b0; l_r_clk = 1'b0; sd = 1'b0; prev_bit = 1'b0;
    #30;
    reset = 1'b1;
    #20;
    period(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    int v0;
    #3;
    reset = 1'b0;
    #1;
    checks++; if (sample_l !== 16'h0) begin errors++; $display("FAIL rst_l: got %h want 0000", sample_l); end
    checks++; if (sample_r !== 16'h0) begin errors++; $display("FAIL rst_r: got %h want 0000", sample_r); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", sample_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", frame_err); end
    #9;
    v0 = vcnt;
    send_frame(16'h4000, 16'hC000, 32, 32);
    send_frame(16'h4000, 16'hC000, 32, 32);
    #100;
    checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL rst_hold_valid: got %0d pulses want 0", vcnt - v0); end
    checks++; if (sample_l !== 16'h0) begin errors++; $display("FAIL rst_hold_l: got %h want 0000", sample_l); end
  endtask

  task automatic test_stereo_pair();
    int v0, e0;
    logic [15:0] er;
    do_reset();
    v0 = vcnt; e0 = ecnt;
    er = STEREO ? 16'hC000 : 16'h4000;
    send_frame(16'h4000, 16'hC000, 32, 32);
    #100;
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL pair_valid1: got %0d want 1", vcnt - v0); end
    checks++; if (sample_l !== 16'h4000) begin errors++; $display("FAIL pair_l: got %h want 4000", sample_l); end
    checks++; if (sample_r !== er) begin errors++; $display("FAIL pair_r: got %h want %h", sample_r, er); end
    send_frame(16'h4000, 16'hC000, 32, 32);
    #100;
    checks++; if (vcnt - v0 !== 2) begin errors++; $display("FAIL pair_valid2: got %0d want 2", vcnt - v0); end
    checks++; if (ecnt - e0 !== 0) begin errors++; $display("FAIL pair_err: got %0d want 0", ecnt - e0); end
  endtask

  task automatic test_latency();
    time dt;
    int  ch;
    logic [15:0] er;
    do_reset();
    ch = STEREO ? 1 : 0;
    er = STEREO ? 16'h0456 : 16'h0123;
    send_frame(16'h0123, 16'h0456, 32, 32);
    #100;
    dt = t_upd - t_lsb[ch];
    checks++; if (!(dt > 0 && dt <= 50)) begin errors++; $display("FAIL lat_lsb: got %0t want 1..50 ns", dt); end
    checks++; if (t_val - t_upd !== 10) begin errors++; $display("FAIL lat_valid: got %0t want 10 ns after update", t_val - t_upd); end
    checks++; if (sample_l !== 16'h0123) begin errors++; $display("FAIL lat_l: got %h want 0123", sample_l); end
    checks++; if (sample_r !== er) begin errors++; $display("FAIL lat_r: got %h want %h", sample_r, er); end
  endtask

  task automatic test_full_scale();
    int v0, e0;
    logic [15:0] er;
    do_reset();
    v0 = vcnt; e0 = ecnt;
    er = STEREO ? 16'h8000 : 16'h7FFF;
    for (int f = 0; f < 100; f++) send_frame(16'h7FFF, 16'h8000, 32, 32);
    #100;
    checks++; if (vcnt - v0 !== 100) begin errors++; $display("FAIL fs_valid: got %0d want 100", vcnt - v0); end
    checks++; if (ecnt - e0 !== 0) begin errors++; $display("FAIL fs_err: got %0d want 0", ecnt - e0); end
    checks++; if (sample_l !== 16'h7FFF) begin errors++; $display("FAIL fs_l: got %h want 7fff", sample_l); end
    checks++; if (sample_r !== er) begin errors++; $display("FAIL fs_r: got %h want %h", sample_r, er); end
  endtask

  task automatic test_frame_err();
    int v0, e0, xv, xe;
    logic [15:0] xl, xr;
    do_reset();
    v0 = vcnt; e0 = ecnt;
    send_frame(16'h1111, 16'h2222, 32, 32);
    #100;
    xr = STEREO ? 16'h2222 : 16'h1111;
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL ferr_a_valid: got %0d want 1", vcnt - v0); end
    checks++; if (sample_r !== xr) begin errors++; $display("FAIL ferr_a_r: got %h want %h", sample_r, xr); end
    send_frame(16'h3333, 16'h4444, 32, 10);
    #100;
    xl = STEREO ? 16'h1111 : 16'h3333;
    xr = STEREO ? 16'h2222 : 16'h3333;
    checks++; if (sample_l !== xl) begin errors++; $display("FAIL ferr_b_l: got %h want %h", sample_l, xl); end
    checks++; if (sample_r !== xr) begin errors++; $display("FAIL ferr_b_r: got %h want %h", sample_r, xr); end
    send_frame(16'h5555, 16'h6666, 32, 32);
    #100;
    xv = STEREO ? 2 : 3; xe = STEREO ? 1 : 0;
    xr = STEREO ? 16'h6666 : 16'h5555;
    checks++; if (vcnt - v0 !== xv) begin errors++; $display("FAIL ferr_c_valid: got %0d want %0d", vcnt - v0, xv); end
    checks++; if (ecnt - e0 !== xe) begin errors++; $display("FAIL ferr_c_err: got %0d want %0d", ecnt - e0, xe); end
    checks++; if (sample_l !== 16'h5555) begin errors++; $display("FAIL ferr_c_l: got %h want 5555", sample_l); end
    checks++; if (sample_r !== xr) begin errors++; $display("FAIL ferr_c_r: got %h want %h", sample_r, xr); end
    send_frame(16'h7777, 16'h0888, 10, 32);
    #100;
    xe = STEREO ? 2 : 1;
    checks++; if (ecnt - e0 !== xe) begin errors++; $display("FAIL ferr_d_err: got %0d want %0d", ecnt - e0, xe); end
    checks++; if (vcnt - v0 !== xv) begin errors++; $display("FAIL ferr_d_valid: got %0d want %0d", vcnt - v0, xv); end
    checks++; if (sample_l !== 16'h5555) begin errors++; $display("FAIL ferr_d_l: got %h want 5555", sample_l); end
    send_frame(16'h1357, 16'h2468, 32, 32);
    #100;
    xv = STEREO ? 3 : 4;
    xr = STEREO ? 16'h2468 : 16'h1357;
    checks++; if (vcnt - v0 !== xv) begin errors++; $display("FAIL ferr_e_valid: got %0d want %0d", vcnt - v0, xv); end
    checks++; if (sample_l !== 16'h1357) begin errors++; $display("FAIL ferr_e_l: got %h want 1357", sample_l); end
    checks++; if (sample_r !== xr) begin errors++; $display("FAIL ferr_e_r: got %h want %h", sample_r, xr); end
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    logic [15:0] xr;
    do_reset();
    send_frame(16'h0ABC, 16'h0DEF, 32, 32);
    #100;
    checks++; if (sample_l !== 16'h0ABC) begin errors++; $display("FAIL mid_pre_l: got %h want 0abc", sample_l); end
    send_slot(1'b0, 16'h1111, 32);
    send_slot(1'b1, 16'h2222, 12);
    reset = 1'b0;
    #1;
    checks++; if (sample_l !== 16'h0) begin errors++; $display("FAIL mid_rst_l: got %h want 0000", sample_l); end
    checks++; if (sample_r !== 16'h0) begin errors++; $display("FAIL mid_rst_r: got %h want 0000", sample_r); end
    #39;
    reset = 1'b1;
    v0 = vcnt;
    send_slot(1'b1, 16'h2222, 20);
    #100;
    checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL mid_partial_valid: got %0d want 0", vcnt - v0); end
    send_frame(16'h0F0F, 16'h7070, 32, 32);
    #100;
    xr = STEREO ? 16'h7070 : 16'h0F0F;
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL mid_valid: got %0d want 1", vcnt - v0); end
    checks++; if (sample_l !== 16'h0F0F) begin errors++; $display("FAIL mid_l: got %h want 0f0f", sample_l); end
    checks++; if (sample_r !== xr) begin errors++; $display("FAIL mid_r: got %h want %h", sample_r, xr); end
  endtask

  task automatic test_mono_word();
    int v0, e0;
    logic [15:0] xr;
    do_reset();
    v0 = vcnt; e0 = ecnt;
    for (int f = 0; f < 3; f++) send_frame(16'h1234, 16'h5678, 32, 32);
    #100;
    xr = STEREO ? 16'h5678 : 16'h1234;
    checks++; if (vcnt - v0 !== 3) begin errors++; $display("FAIL mono_valid: got %0d want 3", vcnt - v0); end
    checks++; if (ecnt - e0 !== 0) begin errors++; $display("FAIL mono_err: got %0d want 0", ecnt - e0); end
    checks++; if (sample_l !== 16'h1234) begin errors++; $display("FAIL mono_l: got %h want 1234", sample_l); end
    checks++; if (sample_r !== xr) begin errors++; $display("FAIL mono_r: got %h want %h", sample_r, xr); end
  endtask

  task automatic test_back_to_back();
    int v0, e0, w0, f0, xv;
    logic [15:0] xl, xr;
    do_reset();
    v0 = vcnt; e0 = ecnt; w0 = v16cnt; f0 = e16cnt;
    send_frame(16'h8001, 16'h7FFE, 16, 16);
    send_frame(16'h00FF, 16'hFF00, 16, 16);
    #100;
    xv = STEREO ? 1 : 2;
    xl = STEREO ? 16'h8001 : 16'h00FF;
    xr = STEREO ? 16'h7FFE : 16'h00FF;
    checks++; if (v16cnt - w0 !== xv) begin errors++; $display("FAIL b2b_mid_valid: got %0d want %0d", v16cnt - w0, xv); end
    checks++; if (s16_l !== xl) begin errors++; $display("FAIL b2b_mid_l: got %h want %h", s16_l, xl); end
    checks++; if (s16_r !== xr) begin errors++; $display("FAIL b2b_mid_r: got %h want %h", s16_r, xr); end
    send_frame(16'hA5A5, 16'h5A5A, 16, 16);
    period(1'b0, prev_bit);
    #100;
    xr = STEREO ? 16'h5A5A : 16'hA5A5;
    checks++; if (v16cnt - w0 !== 3) begin errors++; $display("FAIL b2b_valid16: got %0d want 3", v16cnt - w0); end
    checks++; if (e16cnt - f0 !== 0) begin errors++; $display("FAIL b2b_err16: got %0d want 0", e16cnt - f0); end
    checks++; if (s16_l !== 16'hA5A5) begin errors++; $display("FAIL b2b_l16: got %h want a5a5", s16_l); end
    checks++; if (s16_r !== xr) begin errors++; $display("FAIL b2b_r16: got %h want %h", s16_r, xr); end
    checks++; if (vcnt - v0 !== 3) begin errors++; $display("FAIL b2b_valid32: got %0d want 3", vcnt - v0); end
    checks++; if (ecnt - e0 !== 0) begin errors++; $display("FAIL b2b_err32: got %0d want 0", ecnt - e0); end
    checks++; if (sample_r !== xr) begin errors++; $display("FAIL b2b_r32: got %h want %h", sample_r, xr); end
  endtask

  initial begin
    test_reset();
    test_stereo_pair();
    test_latency();
    test_full_scale();
    test_frame_err();
    test_reset_mid_frame();
    test_mono_word();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
